// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus writer: FSM state encoding, FIFO entry
// layout and a small helper used for counter sizing.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FMARK = 3'd1,
        ST_SETUP      = 3'd2,
        ST_WR_LOW     = 3'd3,
        ST_WR_HIGH    = 3'd4
    } lcd_state_t;

    // FIFO entry layout: {frame_start, rs, data[7:0]}
    localparam int ENTRY_W        = 10;
    localparam int ENTRY_DATA_LSB = 0;
    localparam int ENTRY_RS       = 8;
    localparam int ENTRY_FS       = 9;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_byte_fifo.sv
// Single-clock FIFO holding LCD write entries, with occupancy output.
// A push is refused while full even if a pop happens in the same cycle.
module lcd_byte_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_entry,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic [LW-1:0]      level,
    output logic               full,
    output logic               empty
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset since level guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/lcd_bus_writer.sv
// Buffers command/data bytes and replays each as an 8080-style write cycle
// (SETUP, WR_LOW, WR_HIGH) on the LCD pins. When LCD_BUS_WRITER_FMARK_SYNC_EN
// is defined, a frame_start byte is held in WAIT_FMARK until a rising edge of
// the synchronised tearing signal; otherwise the frame_start bit is ignored.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_valid,
    input  logic [7:0]                  i_data,
    input  logic                        i_rs,
    input  logic                        i_frame_start,
    output logic                        o_ready,
    input  logic                        i_lcd_fmark,
    output logic                        o_lcd_wr,
    output logic                        o_lcd_rs,
    output logic [7:0]                  o_lcd_data,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

    localparam int MAX_CYC = max_int(WR_LOW_CYCLES, WR_HIGH_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    lcd_state_t         state;
    lcd_state_t         state_next;
    lcd_state_t         pop_target;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic               full;
    logic               empty;
    logic               wr_q;
    logic               rs_q;
    logic [7:0]         data_q;

    lcd_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (i_clk),
        .rst_n      (i_reset_n),
        .push       (i_valid),
        .push_entry ({i_frame_start, i_rs, i_data}),
        .pop        (pop),
        .head       (head),
        .level      (o_fifo_level),
        .full       (full),
        .empty      (empty)
    );

    assign o_ready    = !full;
    assign o_busy     = (state != ST_IDLE) || !empty;
    assign o_lcd_wr   = wr_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_data = data_q;

`ifdef LCD_BUS_WRITER_FMARK_SYNC_EN
    logic fmark_meta;
    logic fmark_sync;
    logic fmark_prev;
    logic fmark_rise;

    // Two-flop synchroniser plus delayed copy for rising-edge detection.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fmark_meta <= 1'b0;
            fmark_sync <= 1'b0;
            fmark_prev <= 1'b0;
        end else begin
            fmark_meta <= i_lcd_fmark;
            fmark_sync <= fmark_meta;
            fmark_prev <= fmark_sync;
        end
    end

    // Edges outside WAIT_FMARK are simply not looked at, so nothing latches.
    assign fmark_rise = fmark_sync && !fmark_prev;
    assign pop_target = head[ENTRY_FS] ? ST_WAIT_FMARK : ST_SETUP;
`else
    logic unused_fmark;

    assign unused_fmark = ^{i_lcd_fmark, head[ENTRY_FS]};
    assign pop_target   = ST_SETUP;
`endif

    // Next-state, counter reload and FIFO pop decision.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = pop_target;
                end
            end
`ifdef LCD_BUS_WRITER_FMARK_SYNC_EN
            ST_WAIT_FMARK: begin
                if (fmark_rise) state_next = ST_SETUP;
            end
`endif
            ST_SETUP: begin
                state_next = ST_WR_LOW;
                cnt_next   = CNT_W'(WR_LOW_CYCLES - 1);
            end
            ST_WR_LOW: begin
                if (cnt == '0) begin
                    state_next = ST_WR_HIGH;
                    cnt_next   = CNT_W'(WR_HIGH_CYCLES - 1);
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_WR_HIGH: begin
                if (cnt == '0) begin
                    // Chain straight into the next byte to avoid an IDLE bubble.
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = pop_target;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, counter and registered strobe; reset aborts any write with wr high.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            wr_q  <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            wr_q  <= (state_next != ST_WR_LOW);
        end
    end

    // Output bus only changes on a pop, which never happens while wr is low.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rs_q   <= 1'b0;
            data_q <= 8'h00;
        end else if (pop) begin
            rs_q   <= head[ENTRY_RS];
            data_q <= head[ENTRY_DATA_LSB +: 8];
        end
    end

endmodule
